tt_prog_counter: RTL and testbench



---
 rtl/tt_prog_counter_pkg.sv | 26 ++
 rtl/tt_serial_rx.sv | 74 +++++++
 rtl/tt_prog_counter.sv | 88 ++++++++
 tb/tb_tt_prog_counter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/tt_prog_counter_pkg.sv
// -----------------------------------------------------------------------------
// tt_prog_counter_pkg
// Shared definitions for the serial-programmable up/down counter.
//   clog2()    : bit-count register width for a given counter width
//   MODE_WRAP  : sat_mode value selecting wrap-around at the boundaries
//   MODE_SAT   : sat_mode value selecting saturation at the boundaries
// -----------------------------------------------------------------------------
package tt_prog_counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Number of bits needed to index 0..value-1 (value >= 2).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tt_serial_rx.sv
// -----------------------------------------------------------------------------
// tt_serial_rx
// Oversampled two-wire serial receiver. sclk/sdi are synchronised into clk,
// a rising sclk shifts sdi into the shadow register LSB first, and a
// one-cycle shift_done pulse follows every WIDTH-th shift.
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   sclk, sdi   : asynchronous serial clock / data
//   shadow      : received word (registered)
//   shift_done  : registered pulse, one cycle after the WIDTH-th shift
// -----------------------------------------------------------------------------
module tt_serial_rx
    import tt_prog_counter_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             sdi,
    output logic [WIDTH-1:0] shadow,
    output logic             shift_done
);

    localparam int CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic                   r_sclk_prev;
    logic [WIDTH-1:0]       r_shadow;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic                   r_shift_done;

    logic w_sclk_s;
    logic w_sdi_s;
    logic w_sclk_rise;

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_sdi_s     = r_sdi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync  <= '0;
            r_sdi_sync   <= '0;
            r_sclk_prev  <= 1'b0;
            r_shadow     <= '0;
            r_bit_cnt    <= '0;
            r_shift_done <= 1'b0;
        end else begin
            // sdi goes through the same depth as sclk so data and its
            // strobe stay aligned after synchronisation.
            r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_sdi_sync   <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
            r_sclk_prev  <= w_sclk_s;
            r_shift_done <= 1'b0;
            if (w_sclk_rise) begin
                r_shadow <= {w_sdi_s, r_shadow[WIDTH-1:1]};
                if (r_bit_cnt == LAST_BIT) begin
                    r_bit_cnt    <= '0;
                    r_shift_done <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign shadow     = r_shadow;
    assign shift_done = r_shift_done;

endmodule

// File: rtl/tt_prog_counter.sv
// -----------------------------------------------------------------------------
// tt_prog_counter
// WIDTH-bit up/down counter loaded from a serially programmed shadow register.
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   ena         : tile enable, gates the counter only (not the serial link)
//   load        : copy shadow register into the counter
//   en, up      : count enable and direction (1 = increment)
//   sat_mode    : MODE_WRAP / MODE_SAT behaviour at the boundaries
//   sclk, sdi   : asynchronous serial programming link
//   oe          : output enable for count
//   count       : oe ? internal count : 0
//   tc          : registered terminal-count pulse
//   shift_done  : registered pulse when a full word has been received
// -----------------------------------------------------------------------------
module tt_prog_counter
    import tt_prog_counter_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             load,
    input  logic             en,
    input  logic             up,
    input  logic             sat_mode,
    input  logic             sclk,
    input  logic             sdi,
    input  logic             oe,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             shift_done
);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic [WIDTH-1:0] w_shadow;
    logic [WIDTH-1:0] w_count_next;
    logic             w_step;
    logic             w_at_bound;

    tt_serial_rx #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_serial_rx (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .sdi        (sdi),
        .shadow     (w_shadow),
        .shift_done (shift_done)
    );

    assign w_step     = ena & ~load & en;
    assign w_at_bound = up ? (&r_count) : (r_count == '0);

    always_comb begin
        w_count_next = r_count;
        if (ena) begin
            if (load) begin
                // Shadow is a register, so this is its value before any
                // shift happening on the same edge.
                w_count_next = w_shadow;
            end else if (en) begin
                if (!(w_at_bound && sat_mode == MODE_SAT)) begin
                    // Plain modular arithmetic gives the wrap behaviour.
                    w_count_next = up ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_tc    <= w_step & w_at_bound;
        end
    end

    assign count = oe ? r_count : '0;
    assign tc    = r_tc;

endmodule

// File: tb/tb_tt_prog_counter.sv
module tb_tt_prog_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b1;
    logic       load = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       sat_mode = 1'b0;
    logic       sclk = 1'b0;
    logic       sdi = 1'b0;
    logic       oe = 1'b1;
    logic [7:0] count;
    logic       tc;
    logic       shift_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tt_prog_counter #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .load       (load),
        .en         (en),
        .up         (up),
        .sat_mode   (sat_mode),
        .sclk       (sclk),
        .sdi        (sdi),
        .oe         (oe),
        .count      (count),
        .tc         (tc),
        .shift_done (shift_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift nbits of val LSB first, sclk half-period 4 clk. Optionally
    // pulse load on cycle load_at of the last high phase (edge 3 = shift).
    task automatic send(input logic [7:0] val, input int nbits, input int load_at,
                        input int exp_done, input string tag);
        int         done_seen;
        logic [3:0] pat;
        done_seen = 0;
        pat = 4'b0;
        for (int b = 0; b < nbits; b++) begin
            sclk = 1'b0;
            sdi  = val[b];
            for (int c = 0; c < 4; c++) begin
                tick();
                done_seen += int'(shift_done);
            end
            sclk = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (b == nbits - 1 && c == load_at) load = 1'b1;
                tick();
                if (b == nbits - 1 && c == load_at) load = 1'b0;
                pat[c] = shift_done;
                done_seen += int'(shift_done);
            end
        end
        sclk = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            done_seen += int'(shift_done);
        end
        chk({tag, "_done_cnt"}, done_seen, exp_done);
        if (exp_done == 1) chk({tag, "_done_pos"}, {28'b0, pat}, 32'h4);
    endtask

    task automatic pulse_load();
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        tick();
        tick();
        chk("rst_count", {24'b0, count}, 32'h0);
        chk("rst_tc", {31'b0, tc}, 32'h0);
        chk("rst_done", {31'b0, shift_done}, 32'h0);
        rst = 1'b0;
        tick();

        // Shift 0xA5 and load it
        send(8'hA5, 8, -1, 1, "a5");
        chk("a5_before_load", {24'b0, count}, 32'h0);
        pulse_load();
        chk("a5_load", {24'b0, count}, 32'hA5);
        chk("a5_load_tc", {31'b0, tc}, 32'h0);

        // Wrap up from 0xFE
        send(8'hFE, 8, -1, 1, "fe");
        pulse_load();
        chk("fe_load", {24'b0, count}, 32'hFE);
        en = 1'b1; up = 1'b1; sat_mode = 1'b0;
        tick();
        chk("wrap1", {24'b0, count}, 32'hFF);
        chk("wrap1_tc", {31'b0, tc}, 32'h0);
        tick();
        chk("wrap2", {24'b0, count}, 32'h00);
        chk("wrap2_tc", {31'b0, tc}, 32'h1);
        tick();
        chk("wrap3", {24'b0, count}, 32'h01);
        chk("wrap3_tc", {31'b0, tc}, 32'h0);
        en = 1'b0;

        // Saturate down from 0x01
        send(8'h01, 8, -1, 1, "s01");
        pulse_load();
        chk("s01_load", {24'b0, count}, 32'h01);
        en = 1'b1; up = 1'b0; sat_mode = 1'b1;
        tick();
        chk("sat1", {24'b0, count}, 32'h00);
        chk("sat1_tc", {31'b0, tc}, 32'h0);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk($sformatf("sat%0d", i), {24'b0, count}, 32'h00);
            chk($sformatf("sat%0d_tc", i), {31'b0, tc}, 32'h1);
        end
        en = 1'b0;
        tick();
        chk("sat_hold_tc", {31'b0, tc}, 32'h0);

        // ena=0: counter frozen, serial link still runs
        up = 1'b1; sat_mode = 1'b0;
        ena = 1'b0; load = 1'b1; en = 1'b1;
        send(8'h5A, 8, -1, 1, "ena0");
        chk("ena0_count", {24'b0, count}, 32'h00);
        chk("ena0_tc", {31'b0, tc}, 32'h0);
        load = 1'b0; en = 1'b0; ena = 1'b1;
        pulse_load();
        chk("ena0_shadow", {24'b0, count}, 32'h5A);

        // Load coinciding with the last shift edge sees old shadow
        send(8'h78, 8, -1, 1, "s78");
        send(8'h3C, 8, 2, 1, "s3c");
        chk("same_cycle_load", {24'b0, count}, 32'h78);
        pulse_load();
        chk("second_load", {24'b0, count}, 32'h3C);

        // Reset mid-shift discards partial frame
        en = 1'b1; up = 1'b1;
        tick();
        send(8'hFF, 5, -1, 0, "part");
        en = 1'b0;
        rst = 1'b1;
        tick();
        chk("midrst_count", {24'b0, count}, 32'h0);
        chk("midrst_tc", {31'b0, tc}, 32'h0);
        tick();
        rst = 1'b0;
        send(8'h0F, 8, -1, 1, "s0f");
        chk("s0f_before_load", {24'b0, count}, 32'h0);
        pulse_load();
        chk("s0f_load", {24'b0, count}, 32'h0F);

        // oe=0 gates output only
        oe = 1'b0; en = 1'b1; up = 1'b1; sat_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("oe0_%0d", i), {24'b0, count}, 32'h0);
        end
        en = 1'b0;
        oe = 1'b1;
        #1;
        chk("oe1_count", {24'b0, count}, 32'h12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
